// File: rtl/icache_fill_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | icache_fill_pkg                                                            |
// | Shared constants, types and helpers for the icache miss-fill engine.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package icache_fill_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;
  typedef logic [7:0]  byte_t;
  typedef logic [2:0]  cnt_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LO    = 2'd1;
  localparam logic [1:0] ST_HI    = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  localparam logic [1:0] RVC_FULL_OP = 2'b11;

  // Byte positions inside the fill buffer.
  localparam logic [1:0] BYTE_B0 = 2'd0;
  localparam logic [1:0] BYTE_B1 = 2'd1;
  localparam logic [1:0] BYTE_B2 = 2'd2;
  localparam logic [1:0] BYTE_B3 = 2'd3;

  // Issue limits and last-byte receive counts for each half.
  localparam cnt_t CNT_LO_END  = 3'd2;
  localparam cnt_t CNT_HI_END  = 3'd4;
  localparam cnt_t CNT_LAST_LO = 3'd1;
  localparam cnt_t CNT_LAST_HI = 3'd3;

  localparam addr_t HALF_MASK = 32'hFFFF_FFFE;

  typedef struct packed {
    logic  is_c;
    addr_t addr;
    word_t inst;
  } wr_beat_t;

  function automatic logic is_rvc(input byte_t b0);
    return b0[1:0] != RVC_FULL_OP;
  endfunction

  function automatic word_t assemble_inst(input byte_t b0, input byte_t b1,
                                          input byte_t b2, input byte_t b3,
                                          input logic is_c);
    return is_c ? {16'h0000, b1, b0} : {b3, b2, b1, b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_fill_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | icache_fill_if                                                             |
// | Fetch miss handshake, byte-read memory port and icache write port.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface icache_fill_if;
  import icache_fill_pkg::*;

  logic  miss_valid;
  addr_t miss_addr;
  logic  miss_ready;
  logic  fill_done;

  logic  mem_req;
  addr_t mem_addr;
  logic  mem_gnt;
  logic  mem_rvalid;
  byte_t mem_rdata;

  logic  wr_ready;
  logic  wr_is_c;
  addr_t wr_addr;
  word_t wr_inst;

  modport master (
    input  miss_valid, miss_addr, mem_gnt, mem_rvalid, mem_rdata,
    output miss_ready, fill_done, mem_req, mem_addr,
           wr_ready, wr_is_c, wr_addr, wr_inst
  );

  modport slave (
    output miss_valid, miss_addr, mem_gnt, mem_rvalid, mem_rdata,
    input  miss_ready, fill_done, mem_req, mem_addr,
           wr_ready, wr_is_c, wr_addr, wr_inst
  );

endinterface
`default_nettype wire

// File: rtl/icache_fill.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | icache_fill                                                                |
// | Byte-serial icache miss fill with RVC detection (ICACHE_FILL_RVC_EN).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module icache_fill
  import icache_fill_pkg::*;
(
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          flush,
  icache_fill_if.master bus
);

  logic [1:0] r_state;
  addr_t      r_base;
  cnt_t       r_issue;
  cnt_t       r_rcv;
  byte_t      r_bytes [4];
  logic       r_inflight;
  logic       r_is_c;

  logic       w_busy;
  logic       w_idle_ready;
  logic       w_accept;
  logic       w_req;
  logic       w_rx;
  logic       w_lo_done;
  logic       w_hi_done;
  logic       w_rvc;
  cnt_t       w_issue_lim;
  wr_beat_t   w_beat;

  assign w_busy       = (r_state == ST_LO) || (r_state == ST_HI);
  // A byte granted last cycle may still land; hold off new misses until it has.
  assign w_idle_ready = rdy_in && (r_state == ST_IDLE) && !r_inflight;
  assign w_accept     = w_idle_ready && bus.miss_valid && !flush;
  assign w_issue_lim  = (r_state == ST_LO) ? CNT_LO_END : CNT_HI_END;
  assign w_req        = rdy_in && w_busy && (r_issue < w_issue_lim);
  assign w_rx         = w_busy && bus.mem_rvalid;
  assign w_lo_done    = (r_state == ST_LO) && w_rx && (r_rcv == CNT_LAST_LO);
  assign w_hi_done    = (r_state == ST_HI) && w_rx && (r_rcv == CNT_LAST_HI);

`ifdef ICACHE_FILL_RVC_EN
  // Byte 0 is already buffered by the time byte 1 arrives.
  assign w_rvc = is_rvc(r_bytes[BYTE_B0]);
`else
  assign w_rvc = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_issue    <= '0;
      r_rcv      <= '0;
      r_inflight <= 1'b0;
      r_is_c     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_bytes[i] <= '0;
      end
    end else if (rdy_in) begin
      r_inflight <= bus.mem_gnt;
      if (flush) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              r_base  <= bus.miss_addr & HALF_MASK;
              r_issue <= '0;
              r_rcv   <= '0;
              r_state <= ST_LO;
            end
          end
          ST_LO, ST_HI: begin
            if (bus.mem_gnt) begin
              r_issue <= r_issue + 3'd1;
            end
            if (w_rx) begin
              r_bytes[r_rcv[1:0]] <= bus.mem_rdata;
              r_rcv               <= r_rcv + 3'd1;
            end
            if (w_lo_done) begin
              r_state <= w_rvc ? ST_WRITE : ST_HI;
              r_is_c  <= w_rvc;
            end else if (w_hi_done) begin
              r_state <= ST_WRITE;
              r_is_c  <= 1'b0;
            end
          end
          ST_WRITE: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign w_beat.is_c = r_is_c;
  assign w_beat.addr = r_base;
  assign w_beat.inst = assemble_inst(r_bytes[BYTE_B0], r_bytes[BYTE_B1],
                                     r_bytes[BYTE_B2], r_bytes[BYTE_B3], r_is_c);

  assign bus.miss_ready = w_idle_ready;
  assign bus.mem_req    = w_req;
  assign bus.mem_addr   = r_base + addr_t'(r_issue);
  // A flush landing on the write cycle cancels the strobe.
  assign bus.wr_ready   = rdy_in && (r_state == ST_WRITE) && !flush;
  assign bus.fill_done  = bus.wr_ready;
  assign bus.wr_is_c    = w_beat.is_c;
  assign bus.wr_addr    = w_beat.addr;
  assign bus.wr_inst    = w_beat.inst;

  a_gnt_needs_req: assert property (@(posedge clk_in) disable iff (!rst_in)
                                    bus.mem_gnt |-> bus.mem_req);

endmodule
`default_nettype wire

// File: tb/tb_icache_fill.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_icache_fill                                                             |
// | Self-checking bench: directed scenarios plus randomized fills vs. a model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_icache_fill;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;
  logic flush  = 1'b0;

  icache_fill_if bus();

  icache_fill dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .bus    (bus)
  );

  initial forever #5 clk_in = ~clk_in;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int last_acc_cyc = 0;
  int last_wr_cyc  = 0;

  logic        pend_gnt  = 1'b0;
  logic [31:0] pend_addr = '0;
  logic [7:0]  mem_img [logic [31:0]];
  logic [31:0] stall_addr = '0;
  int          stall_left = 0;

  logic        s_miss_ready, s_mem_req, s_gnt, s_wr_ready, s_fill_done, s_wr_is_c, s_acc;
  logic [31:0] s_mem_addr, s_wr_addr, s_wr_inst;

  // One clock cycle: drive inputs after the falling edge, act as arbiter, sample.
  task automatic tick(input logic rst_n, input logic rdy, input logic flsh,
                      input logic mv, input logic [31:0] maddr, input logic gnt_ok);
    @(negedge clk_in);
    rst_in          = rst_n;
    rdy_in          = rdy | pend_gnt;
    flush           = flsh;
    bus.miss_valid  = mv;
    bus.miss_addr   = maddr;
    bus.mem_rvalid  = pend_gnt;
    bus.mem_rdata   = (pend_gnt && mem_img.exists(pend_addr)) ? mem_img[pend_addr] : 8'($urandom);
    bus.mem_gnt     = 1'b0;
    #1;
    if (bus.mem_req && gnt_ok) begin
      if (stall_left > 0 && bus.mem_addr == stall_addr) stall_left--;
      else bus.mem_gnt = 1'b1;
    end
    #1;
    s_miss_ready = bus.miss_ready;
    s_mem_req    = bus.mem_req;
    s_mem_addr   = bus.mem_addr;
    s_gnt        = bus.mem_gnt;
    s_wr_ready   = bus.wr_ready;
    s_fill_done  = bus.fill_done;
    s_wr_is_c    = bus.wr_is_c;
    s_wr_addr    = bus.wr_addr;
    s_wr_inst    = bus.wr_inst;
    s_acc        = rst_n && rdy_in && mv && !flsh && bus.miss_ready;
    pend_gnt     = bus.mem_gnt;
    pend_addr    = bus.mem_addr;
    cyc++;
  endtask

  task automatic present_miss(input string name, input logic [31:0] addr);
    bit acc = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b1, addr, 1'b1);
      acc = s_acc;
    end
    last_acc_cyc = cyc;
    n_total++;
    if (!acc) begin
      n_bad++;
      $display("FAIL %s accept: miss_ready=%0d want 1 within 20 cycles", name, s_miss_ready);
    end
  endtask

  // One complete fill checked against the instruction-format rules.
  task automatic do_fill(input string name, input logic [31:0] addr,
                         input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3,
                         input int gnt_pct, input int stall_off, input int stall_len,
                         input int rdy_off, input int rdy_len, input int rdy_pct,
                         input int exp_extra);
    logic [31:0] base, exp_inst, wa, wi;
    logic        exp_c, wc, fd, mr;
    logic        rdy;
    int          exp_lat, nb, stalls, lat;
    bit          got;
    logic [31:0] grants [$];
    base = addr & 32'hFFFF_FFFE;
    mem_img[base]         = b0;
    mem_img[base + 32'd1] = b1;
    mem_img[base + 32'd2] = b2;
    mem_img[base + 32'd3] = b3;
`ifdef ICACHE_FILL_RVC_EN
    exp_c = (b0[1:0] != 2'b11);
`else
    exp_c = 1'b0;
`endif
    nb       = exp_c ? 2 : 4;
    exp_lat  = exp_c ? 4 : 7;
    exp_inst = exp_c ? {16'h0000, b1, b0} : {b3, b2, b1, b0};
    stall_addr = base + 32'(stall_off);
    stall_left = (stall_off >= 0) ? stall_len : 0;

    present_miss(name, addr);
    stalls = 0; got = 0; lat = 0; wa = '0; wi = '0; wc = 0; fd = 0; mr = 0;
    for (int k = 1; k <= 80 && !got; k++) begin
      rdy = !((rdy_off > 0) && (k >= rdy_off) && (k < rdy_off + rdy_len))
            && ($urandom_range(99) >= rdy_pct);
      tick(1'b1, rdy, 1'b0, 1'b0, 32'h0, ($urandom_range(99) < gnt_pct));
      if (!rdy_in || (s_mem_req && !s_gnt)) stalls++;
      if (s_gnt) grants.push_back(s_mem_addr);
      if (s_wr_ready) begin
        got = 1; lat = cyc - last_acc_cyc; last_wr_cyc = cyc;
        wa = s_wr_addr; wi = s_wr_inst; wc = s_wr_is_c; fd = s_fill_done; mr = s_miss_ready;
      end
    end
    stall_left = 0;

    n_total++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s wr_ready: never seen, want within 80 cycles", name);
      return;
    end
    exp_lat = exp_lat + ((exp_extra >= 0) ? exp_extra : stalls);
    n_total++;
    if (lat !== exp_lat) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat); end
    n_total++;
    if (wa !== base) begin n_bad++; $display("FAIL %s wr_addr: got %h want %h", name, wa, base); end
    n_total++;
    if (wi !== exp_inst) begin n_bad++; $display("FAIL %s wr_inst: got %h want %h", name, wi, exp_inst); end
    n_total++;
    if (wc !== exp_c) begin n_bad++; $display("FAIL %s wr_is_c: got %0d want %0d", name, wc, exp_c); end
    n_total++;
    if ({fd, mr} !== 2'b10) begin n_bad++; $display("FAIL %s done/ready at write: got %b want 10", name, {fd, mr}); end
    n_total++;
    if (grants.size() != nb) begin
      n_bad++; $display("FAIL %s grant count: got %0d want %0d", name, grants.size(), nb);
    end else begin
      for (int i = 0; i < nb; i++) begin
        n_total++;
        if (grants[i] !== base + 32'(i)) begin
          n_bad++; $display("FAIL %s mem_addr[%0d]: got %h want %h", name, i, grants[i], base + 32'(i));
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    n_total++;
    if ({s_miss_ready, s_mem_req, s_wr_ready, s_fill_done, s_wr_is_c} !== 5'b10000) begin
      n_bad++; $display("FAIL reset flags: got %b want 10000",
                        {s_miss_ready, s_mem_req, s_wr_ready, s_fill_done, s_wr_is_c});
    end
    n_total++;
    if ({s_wr_addr, s_wr_inst, s_mem_addr} !== 96'h0) begin
      n_bad++; $display("FAIL reset data: got %h %h %h want all zero", s_wr_addr, s_wr_inst, s_mem_addr);
    end
  endtask

  task automatic test_compressed();
    do_fill("rvc", 32'h0000_1000, 8'h01, 8'h45, 8'hAA, 8'hBB, 100, -1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_full();
    do_fill("full", 32'h0000_2002, 8'h13, 8'h05, 8'h10, 8'h00, 100, -1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_gnt_stall();
    do_fill("stall", 32'h0000_2002, 8'h13, 8'h05, 8'h10, 8'h00, 100, 2, 3, 0, 0, 0, 3);
  endtask

  task automatic test_rdy_hold();
    do_fill("rdy_hold", 32'h0000_1000, 8'h01, 8'h45, 8'hAA, 8'hBB, 100, -1, 0, 1, 5, 0, 5);
  endtask

  task automatic test_wrap();
    do_fill("wrap", 32'hFFFF_FFFE, 8'h93, 8'h86, 8'h21, 8'h43, 100, -1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_flush();
    bit seen;
    for (int fa = 2; fa <= 3; fa++) begin
      mem_img[32'h3000] = 8'h03; mem_img[32'h3001] = 8'h00;
      mem_img[32'h3002] = 8'h00; mem_img[32'h3003] = 8'h00;
      present_miss("flush", 32'h0000_3000);
      seen = 0;
      for (int k = 1; k <= 10; k++) begin
        tick(1'b1, 1'b1, (k == fa), 1'b0, 32'h0, 1'b1);
        if (s_wr_ready) seen = 1;
        if (k == 3) begin
          n_total++;
          if (s_miss_ready !== 1'b0) begin n_bad++; $display("FAIL flush@%0d ready_low: got %0d want 0", fa, s_miss_ready); end
        end
        if (k == 4) begin
          n_total++;
          if ({s_miss_ready, s_mem_req} !== 2'b10) begin
            n_bad++; $display("FAIL flush@%0d idle: ready/req got %b want 10", fa, {s_miss_ready, s_mem_req});
          end
        end
      end
      n_total++;
      if (seen) begin n_bad++; $display("FAIL flush@%0d no_write: wr_ready got 1 want 0", fa); end
    end
    do_fill("after_flush", 32'h0000_3000, 8'hB7, 8'h02, 8'h11, 8'h22, 100, -1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_flush_write();
    mem_img[32'h2002] = 8'h13; mem_img[32'h2003] = 8'h05;
    mem_img[32'h2004] = 8'h10; mem_img[32'h2005] = 8'h00;
    present_miss("flush_wr", 32'h0000_2002);
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1, 1'b1, (k == 7), 1'b0, 32'h0, 1'b1);
      if (k == 7) begin
        n_total++;
        if ({s_wr_ready, s_fill_done} !== 2'b00) begin
          n_bad++; $display("FAIL flush_wr strobe: got %b want 00", {s_wr_ready, s_fill_done});
        end
      end
    end
    n_total++;
    if ({s_miss_ready, s_wr_ready} !== 2'b10) begin
      n_bad++; $display("FAIL flush_wr idle: ready/wr got %b want 10", {s_miss_ready, s_wr_ready});
    end
  endtask

  task automatic test_miss_with_flush();
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_5000, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    n_total++;
    if ({s_mem_req, s_miss_ready} !== 2'b01) begin
      n_bad++; $display("FAIL miss_flush ignored: req/ready got %b want 01", {s_mem_req, s_miss_ready});
    end
  endtask

  task automatic test_reset_mid();
    mem_img[32'h7000] = 8'hFF; mem_img[32'h7001] = 8'h12;
    mem_img[32'h7002] = 8'h34; mem_img[32'h7003] = 8'h56;
    present_miss("rst_mid", 32'h0000_7000);
    for (int k = 1; k <= 4; k++) tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    n_total++;
    if ({s_miss_ready, s_mem_req, s_wr_ready, s_fill_done, s_wr_is_c} !== 5'b10000) begin
      n_bad++; $display("FAIL rst_mid flags: got %b want 10000",
                        {s_miss_ready, s_mem_req, s_wr_ready, s_fill_done, s_wr_is_c});
    end
    n_total++;
    if ({s_wr_addr, s_wr_inst, s_mem_addr} !== 96'h0) begin
      n_bad++; $display("FAIL rst_mid data: got %h %h %h want all zero", s_wr_addr, s_wr_inst, s_mem_addr);
    end
    do_fill("after_rst", 32'h0000_7000, 8'hFF, 8'h12, 8'h34, 8'h56, 100, -1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    int wr_a;
    do_fill("b2b_a", 32'h0000_6000, 8'h83, 8'h20, 8'h04, 8'h00, 100, -1, 0, 0, 0, 0, 0);
    wr_a = last_wr_cyc;
    do_fill("b2b_b", 32'h0000_6101, 8'h41, 8'h11, 8'h00, 8'h00, 100, -1, 0, 0, 0, 0, 0);
    n_total++;
    if (last_acc_cyc - wr_a !== 1) begin
      n_bad++; $display("FAIL b2b gap: got %0d want 1", last_acc_cyc - wr_a);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      do_fill("rand", $urandom, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              70, -1, 0, 0, 0, 15, -1);
      for (int g = 0; g < int'($urandom_range(2)); g++) tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    end
  endtask

  initial begin
    bus.miss_valid = 1'b0;
    bus.miss_addr  = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    test_reset();
    test_compressed();
    test_full();
    test_gnt_stall();
    test_rdy_hold();
    test_wrap();
    test_flush();
    test_flush_write();
    test_miss_with_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/icache_fill.md
# icache_fill

Miss-fill engine that sits between instruction fetch and the memory arbiter. On an icache miss, it reads the instruction at the miss PC one byte at a time and detects a compressed (RVC) encoding. It then drives the icache write port with the assembled instruction, its address and its is_c flag, and signals fill completion to fetch.

## Interface
- No parameters.
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset, synchronous, active-low.
- `rdy_in` in 1: global ready. When low, all state holds, `mem_req` is 0 and `wr_ready` is 0.
- `flush` in 1: abort any fill (branch redirect).
- `miss_valid` in 1: fetch requests a fill.
- `miss_addr` in 32: miss PC. Bit 0 is ignored and treated as 0.
- `miss_ready` out 1: fill can accept a miss this cycle.
- `fill_done` out 1: one-cycle pulse, coincident with `wr_ready`.
- `mem_req` out 1: byte read request.
- `mem_addr` out 32: byte address of the request.
- `mem_gnt` in 1: arbiter accepted the request this cycle.
- `mem_rvalid` in 1: read byte valid. Asserted exactly one cycle after the grant.
- `mem_rdata` in 8: read byte.
- `wr_ready` out 1: icache write strobe.
- `wr_is_c` out 1: written instruction is 16-bit.
- `wr_addr` out 32: halfword-aligned PC of the instruction.
- `wr_inst` out 32: instruction. Compressed instructions are zero-extended to `{16'h0, half}`.

## Operation
- States: IDLE, LO, HI, WRITE.
- Reset (`rst_in`=0) values:
  - state = IDLE.
  - `miss_ready`=1; `mem_req`=0; `wr_ready`=0; `fill_done`=0; `wr_is_c`=0.
  - `wr_addr`=0; `wr_inst`=0; `mem_addr`=0.
  - Byte buffer, issue counter and receive counter are all 0.
  - `inflight`=0.
- IDLE:
  - `miss_ready` = !`inflight`. `inflight` is a register: 1 iff a grant occurred in the previous cycle.
  - When `miss_valid` & `miss_ready` & !`flush`: latch `base` = `miss_addr` & ~1, clear the counters, go to LO.
- LO:
  - `mem_req` is high while issue count < 2. `mem_addr` = `base` + issue count.
  - Each `mem_gnt` increments the issue count.
  - Each `mem_rvalid` stores `mem_rdata` into byte[receive count] and increments the receive count.
  - When byte 1 is received: if byte0[1:0] != 2'b11, go to WRITE with is_c=1; otherwise go to HI.
- HI: same as LO for offsets 2 and 3 (`mem_addr` = `base`+2, `base`+3). When byte 3 is received, go to WRITE with is_c=0.
- WRITE:
  - Registered outputs `wr_ready`=1 and `fill_done`=1 for exactly one cycle.
  - `wr_addr`=`base`. `wr_inst` = {b3,b2,b1,b0}, or {16'h0,b1,b0} when is_c.
  - Return to IDLE.
- Address arithmetic is modulo 2^32. `base`=32'hFFFF_FFFE reads bytes FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001.
- `flush`:
  - Highest priority in every state. Next state is IDLE.
  - A WRITE cycle coinciding with `flush` asserts neither `wr_ready` nor `fill_done`.
  - A `miss_valid` arriving together with `flush` is ignored.
  - A byte still in flight is discarded. `mem_rvalid` is ignored in IDLE, and `miss_ready` stays low until that byte has returned.
- `mem_rvalid` outside LO/HI is ignored.
- A `mem_gnt` without `mem_req` is a protocol error. Assertion only.

## Timing
- Zero-stall arbiter, miss accepted at cycle t:
  - LO: `mem_req` at t+1 and t+2. Bytes return at t+2 and t+3.
  - Compressed: `wr_ready` at t+4.
  - 32-bit: HI requests at t+4 and t+5. Bytes return at t+5 and t+6. `wr_ready` at t+7.
- Each cycle of `mem_gnt`=0 adds one cycle.
- Next miss accepted no earlier than the cycle after WRITE.
- `rdy_in`=0 cycles freeze state and counters. The arbiter guarantees no grant or rvalid while `rdy_in`=0.

## Configuration
- `ICACHE_FILL_RVC_EN` defined:
  - RVC detection as described above.
- `ICACHE_FILL_RVC_EN` undefined:
  - LO always proceeds to HI.
  - `wr_is_c` is constant 0.
  - Every fill reads 4 bytes.

## Structure
- Shared header holds:
  - State encodings (IDLE=2'd0, LO=2'd1, HI=2'd2, WRITE=2'd3).
  - `RVC_FULL_OP` = 2'b11.
  - Byte-offset constants.
- No sub-module. Byte assembly and RVC detection are inline; the block is a single module.

## Test plan
- Miss at 0x0000_1000, memory bytes 01 45 xx xx, `mem_gnt`=1 -> `wr_ready` 4 cycles after acceptance, `wr_addr`=0x1000, `wr_inst`=0x0000_4501, `wr_is_c`=1, exactly 4 cycles between acceptance and write.
- Miss at 0x0000_2002, bytes 13 05 10 00 -> `wr_ready` at t+7, `wr_inst`=0x0010_0513, `wr_is_c`=0; with the macro undefined, the 16-bit case also fetches 4 bytes and `wr_is_c`=0.
- `mem_gnt` low for 3 cycles before byte 2 -> `wr_ready` at t+10, `mem_addr` held at `base`+2 during the stall, data unchanged.
- `flush` the cycle after the byte-1 grant -> IDLE, `miss_ready` low one cycle then high, returning byte ignored, no `wr_ready`; next miss completes correctly.
- Miss at 0xFFFF_FFFE, 32-bit encoding -> `mem_addr` sequence FFFF_FFFE, FFFF_FFFF, 0, 1; `wr_addr`=0xFFFF_FFFE.
- `rst_in` low mid-HI -> next cycle all outputs at reset values; `rdy_in` low 5 cycles mid-LO -> `wr_ready` delayed exactly 5 cycles.
